// File: rtl/alu_mdu_unit_pkg.sv
// Shared opcode encodings and FSM state type for the ALU / multiply-divide stage.
package alu_mdu_unit_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_NEG  = 5'b01100;
  localparam logic [4:0] OP_NOT  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mdu_unit_mdu_iter.sv
// Shared iterative engine: radix-2 Booth multiply or non-restoring divide on magnitudes,
// one step per enabled cycle, with the signed fix-up applied to the final step's output.
module mdu_iter #(
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 step,
  input  logic                 is_div,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  output logic [W-1:0]         result_hi,
  output logic [W-1:0]         result_lo,
  output logic [$clog2(W)-1:0] count
);

  localparam int SW = $clog2(W);

  logic [W+1:0] hi;
  logic [W-1:0] lo;
  logic         x;
  logic [W-1:0] mcand;
  logic         div_mode;
  logic         neg_q;
  logic         neg_r;

  logic [W+1:0] booth_sum;
  logic [W+1:0] mul_hi_n;
  logic [W-1:0] mul_lo_n;
  logic [W+1:0] div_sh;
  logic [W+1:0] div_r_n;
  logic [W-1:0] div_lo_n;
  logic [W-1:0] rem_mag;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;

  always_comb begin
    a_mag = a[W-1] ? -a : a;
    b_mag = b[W-1] ? -b : b;

    // Booth: hi carries two guard bits so +/- MIN_INT cannot overflow
    case ({lo[0], x})
      2'b01:   booth_sum = hi + {{2{mcand[W-1]}}, mcand};
      2'b10:   booth_sum = hi - {{2{mcand[W-1]}}, mcand};
      default: booth_sum = hi;
    endcase
    mul_hi_n = {booth_sum[W+1], booth_sum[W+1:1]};
    mul_lo_n = {booth_sum[0], lo[W-1:1]};

    div_sh   = {hi[W:0], lo[W-1]};
    div_r_n  = hi[W+1] ? (div_sh + {2'b00, mcand}) : (div_sh - {2'b00, mcand});
    div_lo_n = {lo[W-2:0], ~div_r_n[W+1]};
    rem_mag  = div_r_n[W+1] ? (div_r_n[W-1:0] + mcand) : div_r_n[W-1:0];

    if (div_mode) begin
      result_hi = neg_r ? -rem_mag : rem_mag;
      result_lo = neg_q ? -div_lo_n : div_lo_n;
    end else begin
      result_hi = mul_hi_n[W-1:0];
      result_lo = mul_lo_n;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      hi       <= '0;
      lo       <= '0;
      x        <= 1'b0;
      mcand    <= '0;
      div_mode <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      count    <= '0;
    end else if (start) begin
      hi       <= '0;
      x        <= 1'b0;
      count    <= '0;
      div_mode <= is_div;
      if (is_div) begin
        lo    <= a_mag;
        mcand <= b_mag;
        neg_q <= a[W-1] ^ b[W-1];
        neg_r <= a[W-1];
      end else begin
        lo    <= b;
        mcand <= a;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end
    end else if (step) begin
      count <= count + SW'(1);
      if (div_mode) begin
        hi <= div_r_n;
        lo <= div_lo_n;
        x  <= 1'b0;
      end else begin
        hi <= mul_hi_n;
        lo <= mul_lo_n;
        x  <= lo[0];
      end
    end
  end

endmodule

// File: rtl/alu_mdu_unit.sv
// Y/Z datapath stage: single-cycle ALU plus iterative signed MUL/DIV into Zhi:Zlo.
// Handshake: Zin is accepted only while busy=0; each accepted Zin yields exactly one done pulse.
module alu_mdu_unit
  import alu_mdu_unit_pkg::*;
#(
  parameter int W     = 32,
  parameter int OPC_W = 5
) (
  input  logic             clk,
  input  logic             Clear,
  input  logic [W-1:0]     bus_in,
  input  logic             Yin,
  input  logic             Zin,
  input  logic [OPC_W-1:0] op,
  output logic [W-1:0]     Zhi,
  output logic [W-1:0]     Zlo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output state_t           fsm_state
);

  localparam int SW = $clog2(W);
  localparam logic [SW:0]   WL       = (SW+1)'(W);
  localparam logic [SW-1:0] LAST_RUN = SW'(W - 2);

  logic [W-1:0]  y;
  logic [W-1:0]  alu_res;
  logic          legal;
  logic [SW-1:0] amt;
  logic          is_mul;
  logic          is_div;
  logic          div0;
  logic          start;
  logic [W-1:0]  eng_hi;
  logic [W-1:0]  eng_lo;
  logic [SW-1:0] eng_count;

  always_comb begin
    amt     = bus_in[SW-1:0];
    alu_res = '0;
    legal   = 1'b1;
    case (op)
      OPC_W'(OP_ADD):  alu_res = y + bus_in;
      OPC_W'(OP_SUB):  alu_res = y - bus_in;
      OPC_W'(OP_SHR):  alu_res = y >> amt;
      OPC_W'(OP_SHRA): alu_res = $signed(y) >>> amt;
      OPC_W'(OP_SHL):  alu_res = y << amt;
      OPC_W'(OP_ROR):  alu_res = (y >> amt) | (y << (WL - {1'b0, amt}));
      OPC_W'(OP_ROL):  alu_res = (y << amt) | (y >> (WL - {1'b0, amt}));
      OPC_W'(OP_AND):  alu_res = y & bus_in;
      OPC_W'(OP_OR):   alu_res = y | bus_in;
      OPC_W'(OP_NEG):  alu_res = -bus_in;
      OPC_W'(OP_NOT):  alu_res = ~bus_in;
      default:         legal   = 1'b0;
    endcase
    is_mul = (op == OPC_W'(OP_MUL));
    is_div = (op == OPC_W'(OP_DIV));
    div0   = is_div && (bus_in == '0);
    start  = Zin && (fsm_state == ST_IDLE) && (is_mul || (is_div && !div0));
  end

  mdu_iter #(.W(W)) u_iter (
    .clk       (clk),
    .clear     (Clear),
    .start     (start),
    .step      (busy),
    .is_div    (is_div),
    .a         (y),
    .b         (bus_in),
    .result_hi (eng_hi),
    .result_lo (eng_lo),
    .count     (eng_count)
  );

  always_ff @(posedge clk) begin
    if (Clear) begin
      y         <= '0;
      Zhi       <= '0;
      Zlo       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      fsm_state <= ST_IDLE;
    end else begin
      done <= 1'b0;
      if (Yin) y <= bus_in;
      case (fsm_state)
        ST_IDLE: begin
          if (Zin) begin
            div_zero <= 1'b0;
            if (start) begin
              busy      <= 1'b1;
              fsm_state <= ST_RUN;
            end else if (div0) begin
              Zlo      <= '1;
              Zhi      <= y;
              div_zero <= 1'b1;
              done     <= 1'b1;
            end else begin
              done <= 1'b1;
              if (legal) begin
                Zlo <= alu_res;
                Zhi <= '0;
              end
            end
          end
        end
        ST_RUN: begin
          if (eng_count == LAST_RUN) fsm_state <= ST_FIN;
        end
        ST_FIN: begin
          // the engine performs its last step on this edge; its output is already fixed up
          Zhi       <= eng_hi;
          Zlo       <= eng_lo;
          done      <= 1'b1;
          busy      <= 1'b0;
          fsm_state <= ST_IDLE;
        end
        default: fsm_state <= ST_IDLE;
      endcase
    end
  end

endmodule
